// File: rtl/load_extend_unit.sv
// Two-stage pipelined load-data extender: S1 registers the raw memory beat, S2 registers the
// lane-selected, sign/zero-extended result with its error flag and tag behind a valid/ready handshake.
module load_extend_unit #(
    parameter int XLEN       = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    input  logic [1:0]           in_addr_lo,
    input  logic [1:0]           in_size,
    input  logic                 in_signed,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_data,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_err
);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_e;

    stage_e s1_state_q, s1_state_d;
    stage_e s2_state_q, s2_state_d;

    logic [31:0]          s1_data_q;
    logic [1:0]           s1_addr_q;
    size_e                s1_size_q;
    logic                 s1_signed_q;
    logic [TAG_WIDTH-1:0] s1_tag_q;

    logic [XLEN-1:0]      s2_data_q;
    logic                 s2_err_q;
    logic [TAG_WIDTH-1:0] s2_tag_q;

    logic s2_adv, s1_adv, in_xfer, out_xfer;

    // in_ready depends only on stage occupancy and out_ready, never on in_valid.
    assign s2_adv   = (s2_state_q == EMPTY) || out_ready;
    assign s1_adv   = (s1_state_q == FULL) && s2_adv;
    assign in_ready = (s1_state_q == EMPTY) || s2_adv;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = (s2_state_q == FULL) && out_ready;

    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    always_comb begin
        s1_state_d = s1_state_q;
        s2_state_d = s2_state_q;
        if (in_xfer)     s1_state_d = FULL;
        else if (s1_adv) s1_state_d = EMPTY;
        if (s1_adv)        s2_state_d = FULL;
        else if (out_xfer) s2_state_d = EMPTY;
    end

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_state_q <= EMPTY;
            s2_state_q <= EMPTY;
        end else begin
            s1_state_q <= s1_state_d;
            s2_state_q <= s2_state_d;
        end
    end

    // NOTE: S1 payload needs no reset; it is only observed once its stage is marked FULL.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            s1_data_q   <= in_data;
            s1_addr_q   <= in_addr_lo;
            s1_size_q   <= size_e'(in_size);
            s1_signed_q <= in_signed;
            s1_tag_q    <= in_tag;
        end
    end

    logic [1:0]      byte_lane;
    logic            half_lane;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic            fill;
    logic [XLEN-1:0] ext_data;
    logic            ext_err;

    assign byte_lane = (BIG_ENDIAN != 0) ? ~s1_addr_q    : s1_addr_q;
    assign half_lane = (BIG_ENDIAN != 0) ? ~s1_addr_q[1] : s1_addr_q[1];
    assign byte_sel  = 8'(s1_data_q >> {byte_lane, 3'b000});
    assign half_sel  = 16'(s1_data_q >> {half_lane, 4'b0000});

    // Fill the whole result with the extension bit, then overlay the selected lane.
    always_comb begin
        fill     = 1'b0;
        ext_data = '0;
        ext_err  = 1'b0;
        case (s1_size_q)
            SZ_BYTE: begin
                fill          = s1_signed_q & byte_sel[7];
                ext_data      = {XLEN{fill}};
                ext_data[7:0] = byte_sel;
            end
            SZ_HALF: begin
                if (s1_addr_q[0]) begin
                    ext_err = 1'b1;
                end else begin
                    fill           = s1_signed_q & half_sel[15];
                    ext_data       = {XLEN{fill}};
                    ext_data[15:0] = half_sel;
                end
            end
            SZ_WORD: begin
                if (s1_addr_q != 2'b00) begin
                    ext_err = 1'b1;
                end else begin
                    fill           = s1_signed_q & s1_data_q[31];
                    ext_data       = {XLEN{fill}};
                    ext_data[31:0] = s1_data_q;
                end
            end
            default: ext_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_data_q <= '0;
            s2_err_q  <= 1'b0;
            s2_tag_q  <= '0;
        end else if (s1_adv) begin
            s2_data_q <= ext_data;
            s2_err_q  <= ext_err;
            s2_tag_q  <= s1_tag_q;
        end
    end

    assign out_valid = (s2_state_q == FULL);
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;
    assign out_err   = s2_err_q;

endmodule
